// File: rtl/spram_arbiter.sv
// Two-port round-robin arbiter and power sequencer for one iCE40UP SPRAM256KA.
// Optional deep-sleep stage is compiled in with `define SPRAM_SLEEP_EN.
module spram_arbiter #(
  parameter int unsigned IDLE_CYCLES  = 64,
  parameter int unsigned WAKE_CYCLES  = 2,
  parameter int unsigned SLEEP_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_valid,
  input  logic        m0_we,
  input  logic [13:0] m0_addr,
  input  logic [15:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [15:0] m0_rdata,

  input  logic        m1_valid,
  input  logic        m1_we,
  input  logic [13:0] m1_addr,
  input  logic [15:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [15:0] m1_rdata,

  output logic [13:0] ram_addr,
  output logic [15:0] ram_din,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_cs,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff,
  input  logic [15:0] ram_dout,

  output logic        busy
);

`ifdef SPRAM_SLEEP_EN
  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2,
    ST_SLEEP   = 2'd3
  } state_e;
  localparam int unsigned WAKE_MAX = WAKE_CYCLES + 4;
  localparam int unsigned SLEEP_W  = (SLEEP_CYCLES > 2) ? $clog2(SLEEP_CYCLES) : 1;
  localparam logic [SLEEP_W-1:0] SLEEP_LAST = SLEEP_W'(SLEEP_CYCLES - 1);
`else
  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_e;
  localparam int unsigned WAKE_MAX = WAKE_CYCLES;
`endif

  localparam int unsigned IDLE_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam int unsigned WAKE_W = (WAKE_MAX > 2) ? $clog2(WAKE_MAX) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

  state_e              state_q, state_d;
  logic                rr_last_q, rr_last_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic [WAKE_W-1:0]   wake_cnt_q, wake_cnt_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
`ifdef SPRAM_SLEEP_EN
  logic [SLEEP_W-1:0]  sleep_cnt_q, sleep_cnt_d;
`endif

  logic grant0, grant1, sel, any_valid;

  assign any_valid = m0_valid | m1_valid;

  // Round-robin: on a tie the port that did not win last time is granted.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == ST_ACTIVE) begin
      if (m0_valid && (!m1_valid || rr_last_q)) begin
        grant0 = 1'b1;
      end else if (m1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  // The mux select doubles as rr_last: it holds the last granted port when idle,
  // which keeps ADDRESS/DATAIN from toggling between accesses.
  assign sel       = grant1 | (~grant0 & rr_last_q);
  assign rr_last_d = sel;

  assign m0_ready     = grant0;
  assign m1_ready     = grant1;
  assign ram_cs       = grant0 | grant1;
  assign ram_wren     = (grant0 & m0_we) | (grant1 & m1_we);
  assign ram_addr     = sel ? m1_addr  : m0_addr;
  assign ram_din      = sel ? m1_wdata : m0_wdata;
  assign ram_maskwren = (grant0 && m0_we) ? m0_wmask :
                        (grant1 && m1_we) ? m1_wmask : 4'h0;

  assign rvalid0_d = grant0 & ~m0_we;
  assign rvalid1_d = grant1 & ~m1_we;

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

  assign ram_poweroff = 1'b1;
  assign ram_standby  = (state_q == ST_STANDBY);
  assign busy         = (state_q != ST_ACTIVE);
`ifdef SPRAM_SLEEP_EN
  assign ram_sleep    = (state_q == ST_SLEEP);
`else
  assign ram_sleep    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
`ifdef SPRAM_SLEEP_EN
    sleep_cnt_d = sleep_cnt_q;
`endif
    case (state_q)
      ST_ACTIVE: begin
        if (any_valid) begin
          idle_cnt_d = '0;
        end else if ((IDLE_CYCLES != 0) && (idle_cnt_q == IDLE_LAST)) begin
          state_d    = ST_STANDBY;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + IDLE_W'(1);
        end
      end
      ST_STANDBY: begin
        if (any_valid) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_LOAD;
`ifdef SPRAM_SLEEP_EN
          sleep_cnt_d = '0;
        end else if (sleep_cnt_q == SLEEP_LAST) begin
          state_d     = ST_SLEEP;
          sleep_cnt_d = '0;
        end else begin
          sleep_cnt_d = sleep_cnt_q + SLEEP_W'(1);
`endif
        end
      end
      ST_WAKE: begin
        // Recovery runs to completion even if the requester drops valid.
        if (wake_cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          wake_cnt_d = wake_cnt_q - WAKE_W'(1);
        end
      end
`ifdef SPRAM_SLEEP_EN
      ST_SLEEP: begin
        if (any_valid) begin
          state_d    = ST_WAKE;
          wake_cnt_d = WAKE_W'(WAKE_CYCLES + 3);
        end
      end
`endif
      default: state_d = ST_ACTIVE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      rr_last_q  <= 1'b1;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
    end
  end

`ifdef SPRAM_SLEEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sleep_cnt_q <= '0;
    end else begin
      sleep_cnt_q <= sleep_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Self-checking bench for spram_arbiter with a behavioural SPRAM model.
// Directed vector table for arbitration/data path, hand sequences for power states.
module tb_spram_arbiter;

  logic        clk, rst;
  logic        m0_valid, m0_we, m1_valid, m1_we;
  logic [13:0] m0_addr, m1_addr;
  logic [15:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_ready, m0_rvalid, m1_ready, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic [13:0] ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_cs, ram_standby, ram_sleep, ram_poweroff, busy;

  int n_checks = 0;
  int n_errors = 0;

  spram_arbiter #(
    .IDLE_CYCLES (8),
    .WAKE_CYCLES (2),
    .SLEEP_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_dout(ram_dout),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SPRAM macro model: nibble-masked write, registered read.
  logic [15:0] mem [0:16383];
  logic [15:0] wr_word;
  always @(posedge clk) begin
    if (ram_cs && !ram_standby && !ram_sleep) begin
      if (ram_wren) begin
        wr_word = mem[ram_addr];
        for (int n = 0; n < 4; n++)
          if (ram_maskwren[n]) wr_word[4*n +: 4] = ram_din[4*n +: 4];
        mem[ram_addr] <= wr_word;
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] k);
    m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; m0_wmask = k;
  endtask

  task automatic drive1(input logic v, input logic we, input logic [13:0] a,
                        input logic [15:0] d, input logic [3:0] k);
    m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; m1_wmask = k;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic        v0, we0; logic [13:0] a0; logic [15:0] d0; logic [3:0] k0;
    logic        v1, we1; logic [13:0] a1; logic [15:0] d1; logic [3:0] k1;
    logic        rdy0, rdy1, cs, wren; logic [3:0] mask; logic [13:0] addr;
    logic [15:0] din; logic rv0, rv1; logic [15:0] rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    // v0-v2: m0 full write then read back; v3-v6: masked write over 0xFFFF at 0x3FFF.
    vecs[0]  = '{1'b1,1'b1,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'hFFFF,4'hF,
                 1'b1,1'b0,1'b1,1'b1,4'hF,14'h0010,16'hA5C3,1'b0,1'b0,16'h0};
    vecs[1]  = '{1'b1,1'b0,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'hFFFF,4'hF,
                 1'b1,1'b0,1'b1,1'b0,4'h0,14'h0010,16'hA5C3,1'b0,1'b0,16'h0};
    vecs[2]  = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'hFFFF,4'hF,
                 1'b0,1'b0,1'b0,1'b0,4'h0,14'h0010,16'hA5C3,1'b1,1'b0,16'hA5C3};
    vecs[3]  = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b1,1'b1,14'h3FFF,16'hFFFF,4'hF,
                 1'b0,1'b1,1'b1,1'b1,4'hF,14'h3FFF,16'hFFFF,1'b0,1'b0,16'h0};
    vecs[4]  = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b1,1'b1,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b1,1'b1,1'b1,4'h3,14'h3FFF,16'h1234,1'b0,1'b0,16'h0};
    vecs[5]  = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b1,1'b0,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b1,1'b1,1'b0,4'h0,14'h3FFF,16'h1234,1'b0,1'b0,16'h0};
    vecs[6]  = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b0,1'b0,1'b0,4'h0,14'h3FFF,16'h1234,1'b0,1'b1,16'hFF34};
    // v7-v12: both ports read continuously; grants alternate starting with m0.
    for (int i = 7; i <= 12; i++) begin
      vecs[i] = '{1'b1,1'b0,14'h0010,16'hA5C3,4'hF, 1'b1,1'b0,14'h3FFF,16'h1234,4'h3,
                  1'b0,1'b0,1'b1,1'b0,4'h0,14'h0010,16'hA5C3,1'b0,1'b0,16'h0};
      if (i % 2 == 1) begin
        vecs[i].rdy0 = 1'b1;
        if (i > 7) begin vecs[i].rv1 = 1'b1; vecs[i].rdata = 16'hFF34; end
      end else begin
        vecs[i].rdy1 = 1'b1; vecs[i].addr = 14'h3FFF; vecs[i].din = 16'h1234;
        vecs[i].rv0 = 1'b1; vecs[i].rdata = 16'hA5C3;
      end
    end
    vecs[13] = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b0,1'b0,1'b0,4'h0,14'h3FFF,16'h1234,1'b0,1'b1,16'hFF34};
    // v14: lone m1 request is granted although m1 won last.
    vecs[14] = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b1,1'b0,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b1,1'b1,1'b0,4'h0,14'h3FFF,16'h1234,1'b0,1'b0,16'h0};
    vecs[15] = '{1'b0,1'b0,14'h0010,16'hA5C3,4'hF, 1'b0,1'b0,14'h3FFF,16'h1234,4'h3,
                 1'b0,1'b0,1'b0,1'b0,4'h0,14'h3FFF,16'h1234,1'b0,1'b1,16'hFF34};

    rst = 1'b1;
    drive0(1'b0, 1'b0, 14'h0, 16'h0, 4'h0);
    drive1(1'b0, 1'b0, 14'h3FFF, 16'h0, 4'h0);

    step(); #1;
    check("rst_standby",  ram_standby,  1'b0);
    check("rst_sleep",    ram_sleep,    1'b0);
    check("rst_poweroff", ram_poweroff, 1'b1);
    check("rst_busy",     busy,         1'b0);
    check("rst_rvalid0",  m0_rvalid,    1'b0);
    check("rst_rvalid1",  m1_rvalid,    1'b0);
    check("rst_cs",       ram_cs,       1'b0);
    step(); rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step();
      drive0(vecs[i].v0, vecs[i].we0, vecs[i].a0, vecs[i].d0, vecs[i].k0);
      drive1(vecs[i].v1, vecs[i].we1, vecs[i].a1, vecs[i].d1, vecs[i].k1);
      #1;
      check($sformatf("v%0d_ready0", i), m0_ready,     vecs[i].rdy0);
      check($sformatf("v%0d_ready1", i), m1_ready,     vecs[i].rdy1);
      check($sformatf("v%0d_cs", i),     ram_cs,       vecs[i].cs);
      check($sformatf("v%0d_wren", i),   ram_wren,     vecs[i].wren);
      check($sformatf("v%0d_mask", i),   ram_maskwren, vecs[i].mask);
      check($sformatf("v%0d_addr", i),   ram_addr,     vecs[i].addr);
      check($sformatf("v%0d_din", i),    ram_din,      vecs[i].din);
      check($sformatf("v%0d_rvalid0", i), m0_rvalid,   vecs[i].rv0);
      check($sformatf("v%0d_rvalid1", i), m1_rvalid,   vecs[i].rv1);
      if (vecs[i].rv0) check($sformatf("v%0d_rdata0", i), m0_rdata, vecs[i].rdata);
      if (vecs[i].rv1) check($sformatf("v%0d_rdata1", i), m1_rdata, vecs[i].rdata);
    end

    // A valid in the 8th idle cycle clears the count and blocks standby.
    step(); drive0(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0); drive1(1'b0, 1'b0, 14'h3FFF, 16'h0, 4'h0);
    #1 check("pre_idle_ready0", m0_ready, 1'b1);
    for (int k = 0; k < 7; k++) begin
      step(); m0_valid = 1'b0;
      #1 check($sformatf("idle7_busy%0d", k), busy, 1'b0);
    end
    step(); m0_valid = 1'b1;
    #1 check("edge_valid_ready0", m0_ready, 1'b1);
    check("edge_valid_standby", ram_standby, 1'b0);

    for (int k = 1; k <= 8; k++) begin
      step(); m0_valid = 1'b0;
      #1 check($sformatf("idle%0d_standby", k), ram_standby, 1'b0);
    end
    step(); #1;
    check("standby_rise", ram_standby, 1'b1);
    check("standby_busy", busy, 1'b1);
    check("standby_cs",   ram_cs, 1'b0);
    step(); #1 check("standby_hold", ram_standby, 1'b1);

    // m1 read wakes the macro: one STANDBY cycle, two WAKE cycles, then grant.
    step(); drive1(1'b1, 1'b0, 14'h3FFF, 16'h0, 4'h0);
    #1 check("stby_req_ready1", m1_ready, 1'b0);
    check("stby_req_standby", ram_standby, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      step(); #1;
      check($sformatf("wake%0d_standby", k), ram_standby, 1'b0);
      check($sformatf("wake%0d_busy", k),    busy,        1'b1);
      check($sformatf("wake%0d_ready1", k),  m1_ready,    1'b0);
    end
    step(); #1;
    check("wake_done_busy",   busy,     1'b0);
    check("wake_done_ready1", m1_ready, 1'b1);
    check("wake_done_addr",   ram_addr, 14'h3FFF);
    step(); m1_valid = 1'b0;
    #1 check("wake_rvalid1", m1_rvalid, 1'b1);
    check("wake_rdata1", m1_rdata, 16'hFF34);
    check("wake_rvalid0", m0_rvalid, 1'b0);

    // Reset while in STANDBY with an m0 read pending.
    for (int k = 0; k < 20 && !ram_standby; k++) begin
      step(); #1;
    end
    check("reach_standby", ram_standby, 1'b1);
    step(); drive0(1'b1, 1'b0, 14'h0010, 16'h0, 4'h0); rst = 1'b1;
    #1 check("rst_stby_standby", ram_standby, 1'b0);
    check("rst_stby_rvalid0", m0_rvalid, 1'b0);
    check("rst_stby_rvalid1", m1_rvalid, 1'b0);
    check("rst_stby_busy",    busy,      1'b0);
    step(); rst = 1'b0;
    #1 check("post_rst_ready0", m0_ready, 1'b1);
    check("post_rst_ready1", m1_ready, 1'b0);
    step(); m0_valid = 1'b0;
    #1 check("post_rst_rvalid0", m0_rvalid, 1'b1);
    check("post_rst_rdata0", m0_rdata, 16'hA5C3);

    // Reset with a read response in flight drops rvalid at once.
    step(); m0_valid = 1'b1;
    #1 check("inflight_ready0", m0_ready, 1'b1);
    step(); m0_valid = 1'b0;
    #1 check("inflight_rvalid0", m0_rvalid, 1'b1);
    rst = 1'b1;
    #1 check("inflight_rst_rvalid0", m0_rvalid, 1'b0);
    step(); rst = 1'b0;

`ifdef SPRAM_SLEEP_EN
    for (int k = 0; k < 20 && !ram_standby; k++) begin
      step(); #1;
    end
    check("sl_reach_standby", ram_standby, 1'b1);
    for (int k = 2; k <= 16; k++) begin
      step(); #1 check($sformatf("sl_stby%0d_sleep", k), ram_sleep, 1'b0);
    end
    step(); #1;
    check("sleep_rise", ram_sleep, 1'b1);
    check("sleep_standby", ram_standby, 1'b0);
    step(); m0_valid = 1'b1;
    #1 check("sleep_req_ready0", m0_ready, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(); #1;
      check($sformatf("sl_wake%0d_busy", k),   busy,      1'b1);
      check($sformatf("sl_wake%0d_ready0", k), m0_ready,  1'b0);
      check($sformatf("sl_wake%0d_sleep", k),  ram_sleep, 1'b0);
    end
    step(); #1 check("sl_wake_done_ready0", m0_ready, 1'b1);
    step(); m0_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
